hazard_sequencer: RTL
=====================

Name: hazard_sequencer

Overview:
- Registered pipeline-control sequencer for the 5-stage RV32 core with branches resolved in ID.
- Replaces per-cycle combinational hazard decisions with a small FSM and bubble counter. It arbitrates three stall sources (load-use, branch operand dependency, I/D-cache miss freeze) and branch flush into one consistent set of pipeline write-enable/flush/bubble controls.
- Sits beside the ID stage; drives PC, IF/ID, ID/EX and global pipeline-freeze controls.

Parameters:
- BRANCH_OP, 7'b1100011, opcode of conditional branches (operands compared in ID).
- LD_BR_EX_BUBBLES, 2, bubbles when a load in EX feeds a branch in ID.
- CNT_W, 32, width of performance counters (used only under the optional feature).

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, synchronous, active-low
- icache_stall  in  1  I-cache miss in progress
- dcache_stall  in  1  D-cache miss in progress
- IF_ID_op  in  7  opcode of instruction in ID
- IF_ID_rs1  in  5  source register 1 in ID
- IF_ID_rs2  in  5  source register 2 in ID
- ID_EX_memread  in  1  instruction in EX is a load
- ID_EX_regwrite  in  1  instruction in EX writes rd
- ID_EX_rd  in  5  destination register in EX
- EX_MEM_memread  in  1  instruction in MEM is a load
- EX_MEM_rd  in  5  destination register in MEM
- branch_taken  in  1  ID comparator result, taken branch/jump redirect
- pc_write  out  1  PC register enable
- IF_ID_write  out  1  IF/ID register enable
- IF_ID_flush  out  1  clear IF/ID to NOP
- ID_EX_bubble  out  1  insert NOP into ID/EX, zeroing control bits
- pipe_freeze  out  1  hold every pipeline register and PC
- perf_stall_cnt  out  CNT_W  bubble cycles inserted
- perf_flush_cnt  out  CNT_W  IF/ID flushes issued
- perf_freeze_cnt  out  CNT_W  cache-freeze cycles

Behaviour:
- State: RUN, STALL; 2-bit bubble counter `rem`. Outputs are Mealy: combinational from state and inputs.
- While rst_n=0: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, pipe_freeze=0. The clock edge with rst_n=0 sets state=RUN, rem=0 and counters=0. This applies mid-operation too; any pending bubbles are discarded.
- Match terms ignore x0 (rd==0 never matches). Match means rd==rs1 or rd==rs2. is_br = (IF_ID_op==BRANCH_OP).
- Bubble need n, evaluated in RUN:
  - ID_EX_memread&&match(ID_EX_rd)&&is_br -> LD_BR_EX_BUBBLES.
  - Else ID_EX_memread&&match(ID_EX_rd) -> 1.
  - Else ID_EX_regwrite&&match(ID_EX_rd)&&is_br -> 1.
  - Else EX_MEM_memread&&match(EX_MEM_rd)&&is_br -> 1.
  - Else 0.
- Freeze (icache_stall|dcache_stall) has highest priority in any state:
  - pipe_freeze=1, pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0.
  - State and rem hold; detection and branch_taken are ignored and re-evaluated after the freeze.
- RUN, no freeze, n>0:
  - pc_write=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=0.
  - branch_taken is ignored because operands are stale.
  - If n>1: next state=STALL, rem=n-1. Otherwise stay in RUN.
- RUN, no freeze, n=0: pc_write=1, IF_ID_write=1, ID_EX_bubble=0, IF_ID_flush=branch_taken.
- STALL, no freeze:
  - Detectors and branch_taken are ignored; same outputs as a stall cycle.
  - rem decrements; at rem==1 the next state is RUN with rem=0.
  - RUN then re-evaluates, so stalls chain naturally.
- Latency: a hazard presented in cycle t stalls cycles t..t+n-1. A flush is issued in the same cycle branch_taken is accepted.

Optional Feature:
- Macro HAZARD_SEQ_PERF_EN.
- Defined: three CNT_W counters, saturating at all-ones, cleared by reset.
  - perf_stall_cnt increments on every cycle with ID_EX_bubble=1 and rst_n=1.
  - perf_flush_cnt increments on every IF_ID_flush=1 with rst_n=1.
  - perf_freeze_cnt increments on every pipe_freeze=1.
- Undefined: the ports remain and are tied to 0; no counter flops.

Decomposition:
- Shared core package holds: opcode constants (BRANCH_OP, JAL/JALR/LOAD), the state enum (RUN, STALL), and the register-index width constant (5).
- Sub-module hazard_match: combinational computation of n from register/opcode inputs. The FSM, counters and output muxing stay in the top.

Test Plan:
- lw x5 in EX, add x6,x5,x1 in ID -> 1 cycle with pc_write=0, ID_EX_bubble=1, then RUN with pc_write=1; perf_stall_cnt=1.
- lw x5 in EX, beq x5,x0 in ID -> 2 bubble cycles (state STALL, rem=1 in the second), no flush even with branch_taken=1; the 3rd cycle accepts branch_taken=1 -> IF_ID_flush=1.
- lw x0 in EX, add x6,x0,x0 in ID -> no stall (x0 excluded).
- dcache_stall=1 for 4 cycles arriving in the STALL rem=1 cycle -> pipe_freeze=1 for 4 cycles, rem held at 1, then 1 more bubble; perf_freeze_cnt=4.
- rst_n=0 during STALL -> outputs at reset values that cycle, next cycle state=RUN, rem=0, counters 0.
- branch_taken=1 with no hazard and no freeze -> IF_ID_flush=1 and pc_write=1 in the same cycle; perf_flush_cnt=1.

Source files
------------

// File: rtl/hazard_sequencer_pkg.sv
// Shared core definitions for the hazard sequencer: opcodes, FSM states, register-index width.
package hazard_sequencer_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [6:0] BRANCH_OP_C = 7'b1100011;
  localparam logic [6:0] JAL_OP      = 7'b1101111;
  localparam logic [6:0] JALR_OP     = 7'b1100111;
  localparam logic [6:0] LOAD_OP     = 7'b0000011;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // x0 is hardwired to zero, so it can never carry a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs1,
                                     input logic [REG_W-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/hazard_sequencer_match.sv
// Combinational bubble-need calculation from the ID/EX/MEM register and opcode fields.
module hazard_match
  import hazard_sequencer_pkg::*;
#(
  parameter logic [6:0]  BRANCH_OP        = 7'b1100011,
  parameter int unsigned LD_BR_EX_BUBBLES = 2
) (
  input  logic [6:0]       IF_ID_op,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic             ID_EX_memread,
  input  logic             ID_EX_regwrite,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             EX_MEM_memread,
  input  logic [REG_W-1:0] EX_MEM_rd,
  output logic [1:0]       n
);

  logic is_br;
  logic ex_hit;
  logic mem_hit;

  assign is_br   = (IF_ID_op == BRANCH_OP);
  assign ex_hit  = reg_match(ID_EX_rd, IF_ID_rs1, IF_ID_rs2);
  assign mem_hit = reg_match(EX_MEM_rd, IF_ID_rs1, IF_ID_rs2);

  always_comb begin
    n = 2'd0;
    if (ID_EX_memread && ex_hit && is_br)
      n = 2'(LD_BR_EX_BUBBLES);
    else if (ID_EX_memread && ex_hit)
      n = 2'd1;
    else if (ID_EX_regwrite && ex_hit && is_br)
      n = 2'd1;
    else if (EX_MEM_memread && mem_hit && is_br)
      n = 2'd1;
  end

endmodule

// File: rtl/hazard_sequencer.sv
// Registered pipeline hazard sequencer (RUN/STALL FSM + bubble counter).
// Optional performance counters enabled by defining HAZARD_SEQ_PERF_EN.
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter logic [6:0]  BRANCH_OP        = 7'b1100011,
  parameter int unsigned LD_BR_EX_BUBBLES = 2,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic [6:0]       IF_ID_op,
  input  logic [REG_W-1:0] IF_ID_rs1,
  input  logic [REG_W-1:0] IF_ID_rs2,
  input  logic             ID_EX_memread,
  input  logic             ID_EX_regwrite,
  input  logic [REG_W-1:0] ID_EX_rd,
  input  logic             EX_MEM_memread,
  input  logic [REG_W-1:0] EX_MEM_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_freeze_cnt
);

  state_t     state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic [1:0] n;
  logic       freeze;

  hazard_match #(
    .BRANCH_OP       (BRANCH_OP),
    .LD_BR_EX_BUBBLES(LD_BR_EX_BUBBLES)
  ) u_match (
    .IF_ID_op      (IF_ID_op),
    .IF_ID_rs1     (IF_ID_rs1),
    .IF_ID_rs2     (IF_ID_rs2),
    .ID_EX_memread (ID_EX_memread),
    .ID_EX_regwrite(ID_EX_regwrite),
    .ID_EX_rd      (ID_EX_rd),
    .EX_MEM_memread(EX_MEM_memread),
    .EX_MEM_rd     (EX_MEM_rd),
    .n             (n)
  );

  assign freeze = icache_stall | dcache_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    rem_nxt      = rem;
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (!rst_n) begin
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
    end else if (freeze) begin
      pipe_freeze = 1'b1;
    end else if (state == RUN) begin
      if (n != 2'd0) begin
        // Branch operands are stale while stalling, so branch_taken is not honoured.
        ID_EX_bubble = 1'b1;
        if (n > 2'd1) begin
          state_nxt = STALL;
          rem_nxt   = n - 2'd1;
        end
      end else begin
        pc_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = branch_taken;
      end
    end else begin
      ID_EX_bubble = 1'b1;
      if (rem <= 2'd1) begin
        state_nxt = RUN;
        rem_nxt   = '0;
      end else begin
        rem_nxt = rem - 2'd1;
      end
    end
  end

`ifdef HAZARD_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt  <= '0;
      perf_flush_cnt  <= '0;
      perf_freeze_cnt <= '0;
    end else begin
      if (ID_EX_bubble && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + CNT_W'(1);
      if (IF_ID_flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (pipe_freeze && (perf_freeze_cnt != '1))
        perf_freeze_cnt <= perf_freeze_cnt + CNT_W'(1);
    end
  end
`else
  assign perf_stall_cnt  = '0;
  assign perf_flush_cnt  = '0;
  assign perf_freeze_cnt = '0;
`endif

endmodule
